axi4_lite_master: RTL

Single-outstanding AXI4-Lite initiator that turns a simple command/response interface into AXI4-Lite read and write transactions. It drives the AXI read, write and write-response channels of the AXI-to-APB bridge (AXI4-Lite slave plus APB master, mux and slaves) from an internal requester, such as a CPU stub or test sequencer. It owns the handshake sequencing on all five channels and keeps a saturating count of error responses.

---
 rtl/axi4_lite_master.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
//
// Single-outstanding AXI4-Lite initiator. It accepts one command at a time on a
// simple valid/ready command port, runs the matching AXI4-Lite read or write,
// and returns the captured data and response on a valid/ready response port.
// It also keeps a saturating count of non-OKAY responses.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising ACLK edge where VALID and READY are both high. Once VALID is
// raised, it stays high with its payload stable until that edge. The only
// exception is ARESET.
//
// Ports
//   ACLK, ARESET                  clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command in
//   rsp_valid/ready/write/rdata/resp         response out
//   busy                          high whenever the FSM is not idle
//   err_count                     saturating count of BRESP/RRESP != OKAY
//   AW*, W*, B*, AR*, R*          AXI4-Lite initiator channels
//   dbg_state                     current FSM state, for checkers
// -----------------------------------------------------------------------------
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic [7:0]              err_count,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_bready;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_rsp_valid;
  logic                    r_rsp_write;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;
  logic [7:0]              r_err_count;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_b_hs;
  logic w_r_hs;
  logic w_err_evt;

  assign w_aw_hs   = r_awvalid & AWREADY;
  assign w_w_hs    = r_wvalid & WREADY;
  // "done" includes a handshake happening this very edge, so AW and W may
  // complete in the same cycle or in either order.
  assign w_aw_done = r_aw_done | w_aw_hs;
  assign w_w_done  = r_w_done | w_w_hs;
  // BREADY/RREADY are only ever high in WR_RESP/RD_DATA, so a late BVALID or
  // RVALID elsewhere can never count as a handshake.
  assign w_b_hs    = r_bready & BVALID;
  assign w_r_hs    = r_rready & RVALID;
  assign w_err_evt = (w_b_hs && (BRESP != 2'b00)) || (w_r_hs && (RRESP != 2'b00));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_err_count <= 8'd0;
    end else begin
      if (w_err_evt && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_wstrb <= cmd_wstrb;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end

        S_WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          r_aw_done <= w_aw_done;
          r_w_done  <= w_w_done;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= BRESP;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RD_REQ: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_resp  <= RRESP;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign err_count = r_err_count;

  // One address register feeds both AW and AR; only one channel is active.
  assign AWADDR  = r_addr;
  assign ARADDR  = r_addr;
  assign AWVALID = r_awvalid;
  assign WDATA   = r_wdata;
  assign WSTRB   = r_wstrb;
  assign WVALID  = r_wvalid;
  assign BREADY  = r_bready;
  assign ARVALID = r_arvalid;
  assign RREADY  = r_rready;

endmodule
